sig_lut_loader: RTL
===================

# sig_lut_loader

Runtime loader and lookup port for the sigmoid activation table. It replaces file-time table initialisation: table entries stream in over a valid/ready interface and are written into an internal RAM. A lookup port then serves neuron activations using the same signed-input-to-index mapping. It sits between the host/DMA weight-loading path and the neuron activation stage, so the activation table can be reloaded without resynthesis.

## Interface
Parameters:
- `inWidth`, 10, width of the signed activation input; table depth is 2**inWidth.
- `dataWidth`, 16, width of each table entry and of the lookup output.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  one-cycle pulse; begins (or restarts) a table load.
- `s_valid`  in  1  table word valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `s_data`  in  dataWidth  table entry. Entries arrive in index order 0..2**inWidth-1.
- `s_last`  in  1  marks the final entry of a load.
- `x`  in  inWidth  signed lookup input (two's complement).
- `out`  out  dataWidth  registered lookup result.
- `table_valid`  out  1  a complete, error-free table is loaded.
- `busy`  out  1  a load is in progress.
- `load_err`  out  1  sticky; the last load was malformed.

## Operation
- FSM states: `IDLE`, `LOAD`, `READY`, `ERR`. Reset enters `IDLE`.
- `IDLE`/`READY`/`ERR` with `load_start`=1: go to `LOAD`. On entry, `wr_idx` is cleared, `table_valid` is cleared, and `load_err` is cleared.
- `LOAD` behaviour:
  - `s_ready`=1 and `busy`=1.
  - A transfer occurs when `s_valid`&&`s_ready`. It writes `s_data` to `mem[wr_idx]` and increments `wr_idx`.
  - `wr_idx` is inWidth+1 bits wide.
- `LOAD` exits:
  - Transfer with `s_last`=1 and `wr_idx`==2**inWidth-1: go to `READY` and set `table_valid`.
  - Transfer with `s_last`=1 and `wr_idx`!=2**inWidth-1 (early last): the word is still written; go to `ERR` and set `load_err`.
  - Transfer with `s_last`=0 and `wr_idx`==2**inWidth-1 (missing last): the word is written; go to `ERR` and set `load_err`.
  - `load_start` during `LOAD` aborts the current load and restarts it: `wr_idx` goes to 0 and the state stays `LOAD`. If a transfer occurs in the same cycle, it is discarded.
- Outside `LOAD`, `s_ready`=0. Any `s_valid` is ignored.
- Index mapping: idx = x + 2**(inWidth-1) modulo 2**inWidth. This is implemented as an inversion of x[inWidth-1].
  - x = -2**(inWidth-1) maps to idx 0.
  - x = 0 maps to idx 2**(inWidth-1).
  - x = 2**(inWidth-1)-1 maps to idx 2**inWidth-1.
- Lookup: `out` <= `table_valid` ? `mem[idx(x)]` : 0.
- No read/write collision is possible, because lookups return 0 whenever `table_valid`=0.
- RAM contents are not reset. After reset, or after an aborted or failed load, the table is treated as invalid regardless of its contents.

## Timing
- Reset values: `s_ready`=0, `busy`=0, `table_valid`=0, `load_err`=0, `out`=0, `wr_idx`=0, state `IDLE`.
- `rst_n` low mid-load: all outputs return to reset values immediately (asynchronously). A new `load_start` is then required.
- `s_ready` rises the cycle after `load_start` is sampled. It stays high every cycle in `LOAD`; there is no backpressure gaps from the loader.
- `table_valid` and `load_err` update the cycle after the terminating transfer. `busy` falls on that same edge.
- Lookup latency: 1 cycle. `x` sampled at edge n produces `out` after edge n. A new `x` is accepted every cycle.
- `out` first reflects the new table on the edge after `table_valid` rises.
- `out` is forced to 0 starting the cycle after `load_start` is sampled.
- Minimum load time: 2**inWidth cycles, plus 1 cycle of start latency.

## Structure
- Package `sig_lut_pkg` contains:
  - the state enum `sig_lut_state_t` (`IDLE`, `LOAD`, `READY`, `ERR`);
  - the function `sig_idx(x)`, which flips the MSB;
  - localparam `SIG_DEPTH` = 2**inWidth as the default-size constant.
- One sub-module, `sig_lut_ram`: a simple dual-port synchronous RAM with one write port and one registered read port, depth 2**inWidth and width dataWidth. The FSM, counter and error logic stay in `sig_lut_loader`.

## Test plan
- Full ramp load: after `load_start`, send 1024 words with data=index and `s_last` on word 1023.
  - Required: `table_valid`=1 and `load_err`=0.
  - x=10'h000 gives out=512 one cycle later.
  - x=10'h200 (-512) gives 0.
  - x=10'h1FF gives 1023.
  - x=10'h3FF (-1) gives 511.
- Throttled source: random `s_valid` gaps at roughly 50% duty during the ramp load.
  - Required: identical results to the full ramp load.
  - `busy`=1 throughout the load.
  - Lookups return 0 during the load.
- Early last: `s_last` on word 99.
  - Required: state `ERR`, `load_err`=1, `table_valid`=0, `s_ready`=0.
  - All lookups return 0.
- Missing last: 1024 words with `s_last`=0.
  - Required: `load_err`=1, `table_valid`=0.
  - A word 1025 held on `s_valid` is not accepted.
- Abort and reset:
  - Pulse `load_start` at word 300. Required: `wr_idx` restarts, and a following clean 1024-word load succeeds.
  - Assert `rst_n`=0 at word 500. Required: outputs are at reset values within the same cycle.
- Reload from `READY`: load the ramp, then load an inverted ramp (1023-index).
  - Required: x=0 gives 511 after the second `table_valid` rises.
  - `out`=0 throughout the second load.

Source files
------------

// File: rtl/sig_lut_pkg.sv
// rtl/sig_lut_pkg.sv - shared types and helpers for the sigmoid table loader
package sig_lut_pkg;

  localparam int SIG_IN_WIDTH = 10;
  localparam int SIG_DEPTH    = 2 ** SIG_IN_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY,
    ERR
  } sig_lut_state_t;

  // Signed input to table index: adding half the depth is just an MSB flip.
  function automatic logic [31:0] sig_idx(input logic [31:0] x, input int width);
    return x ^ (32'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/sig_lut_ram.sv
// rtl/sig_lut_ram.sv - simple dual-port RAM, one write port, one registered read port
module sig_lut_ram #(
  parameter int addrWidth = 10,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addrWidth-1:0] waddr,
  input  logic [dataWidth-1:0] wdata,
  input  logic [addrWidth-1:0] raddr,
  output logic [dataWidth-1:0] rdata
);

  logic [dataWidth-1:0] mem [2**addrWidth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sig_lut_loader.sv
// rtl/sig_lut_loader.sv - streaming loader and lookup port for the sigmoid activation table
module sig_lut_loader
  import sig_lut_pkg::*;
#(
  parameter int inWidth   = SIG_IN_WIDTH,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [dataWidth-1:0] s_data,
  input  logic                 s_last,
  input  logic [inWidth-1:0]   x,
  output logic [dataWidth-1:0] out,
  output logic                 table_valid,
  output logic                 busy,
  output logic                 load_err
);

  typedef logic [inWidth-1:0] idx_t;
  typedef logic [inWidth:0]   cnt_t;

  localparam cnt_t LAST_IDX = cnt_t'((1 << inWidth) - 1);

  sig_lut_state_t       state, state_n;
  cnt_t                 wr_idx, wr_idx_n;
  logic                 table_valid_n, load_err_n;
  logic                 we;
  logic                 rd_gate;
  idx_t                 rd_idx;
  logic [dataWidth-1:0] rd_data;

  assign rd_idx = idx_t'(sig_idx(32'(x), inWidth));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_idx      <= '0;
      table_valid <= 1'b0;
      load_err    <= 1'b0;
      rd_gate     <= 1'b0;
    end else begin
      state       <= state_n;
      wr_idx      <= wr_idx_n;
      table_valid <= table_valid_n;
      load_err    <= load_err_n;
      // Drop the read gate on the start edge so out is zero from the next cycle.
      rd_gate     <= table_valid & ~load_start;
    end
  end

  always_comb begin
    state_n       = state;
    wr_idx_n      = wr_idx;
    table_valid_n = table_valid;
    load_err_n    = load_err;
    we            = 1'b0;
    case (state)
      LOAD: begin
        if (load_start) begin
          wr_idx_n = '0;
        end else if (s_valid) begin
          we       = 1'b1;
          wr_idx_n = wr_idx + cnt_t'(1);
          if (s_last && wr_idx == LAST_IDX) begin
            state_n       = READY;
            table_valid_n = 1'b1;
          end else if (s_last || wr_idx == LAST_IDX) begin
            state_n    = ERR;
            load_err_n = 1'b1;
          end
        end
      end
      default: begin
        if (load_start) begin
          state_n       = LOAD;
          wr_idx_n      = '0;
          table_valid_n = 1'b0;
          load_err_n    = 1'b0;
        end
      end
    endcase
  end

  assign s_ready = (state == LOAD);
  assign busy    = (state == LOAD);
  assign out     = rd_gate ? rd_data : '0;

  sig_lut_ram #(
    .addrWidth(inWidth),
    .dataWidth(dataWidth)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_idx[inWidth-1:0]),
    .wdata(s_data),
    .raddr(rd_idx),
    .rdata(rd_data)
  );

endmodule
